bounded_updown_counter: RTL
===========================

Name: bounded_updown_counter

Overview:
- Parametrised successor of the team's 4-bit up/down counter with load.
- Adds:
  - configurable width;
  - programmable step size;
  - runtime lower and upper bounds;
  - wrap or saturate mode;
  - an enable prescaler;
  - over/underflow event pulses and a sticky flag.
- Drives timing and sequencing in the TinyTapeout tile; the top level maps its fields onto ui_in/uo_out/uio pins.

Parameters:
- WIDTH, 8: counter and bound width in bits.
- STEP_W, 4: width of the step input.
- PRESC_W, 8: width of the prescaler divide value.
- RST_VAL, 0: count value after reset (WIDTH bits).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; feeds the prescaler.
- up  in  1  direction: 1 = up, 0 = down.
- sat_mode  in  1  1 = saturate at bounds, 0 = wrap to the opposite bound.
- step  in  STEP_W  increment/decrement amount per advance.
- presc_div  in  PRESC_W  advance once every presc_div+1 enabled cycles.
- lo_bound  in  WIDTH  inclusive lower bound.
- hi_bound  in  WIDTH  inclusive upper bound.
- load  in  1  load request.
- load_val  in  WIDTH  value to load.
- clr_flags  in  1  clears ovf_sticky.
- count  out  WIDTH  current count (registered).
- tick  out  1  registered; 1 for the cycle after an advance edge.
- ovf_pulse  out  1  registered; 1 when the last advance crossed hi_bound.
- unf_pulse  out  1  registered; 1 when the last advance crossed lo_bound.
- ovf_sticky  out  1  set by either pulse; held until clr_flags.
- at_max  out  1  combinational: count == hi_bound.
- at_min  out  1  combinational: count == lo_bound.
- cfg_err  out  1  combinational: lo_bound > hi_bound.

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=RST_VAL; prescaler count pcnt=0; tick=0, ovf_pulse=0, unf_pulse=0, ovf_sticky=0.
  - Reset overrides every other input.
- Priority per edge: rst > cfg_err hold > load > advance > idle.
- cfg_err=1:
  - count and pcnt hold; load and advance are ignored; pulses=0.
  - The sticky flag still responds to clr_flags.
- Load:
  - load_val is clamped: below lo_bound -> lo_bound; above hi_bound -> hi_bound.
  - pcnt=0; tick and pulses=0 that cycle.
  - load with en=1 is a load only; no advance occurs.
- Prescaler:
  - While en=1 and not loading: if pcnt==presc_div, an advance fires and pcnt=0; otherwise pcnt=pcnt+1 with no advance.
  - en=0: pcnt holds.
  - presc_div=0 advances on every enabled cycle.
  - If presc_div is lowered below the current pcnt, pcnt wraps through its full range; no reset is implied.
- Advance arithmetic, computed in WIDTH+1 bits with no truncation before compare:
  - up: sum = count + step. If sum > hi_bound: count = lo_bound when wrapping, count = hi_bound when saturating; ovf_pulse=1. Otherwise count = sum.
  - down: diff = count - step, signed. If diff < lo_bound: count = hi_bound when wrapping, count = lo_bound when saturating; unf_pulse=1. Otherwise count = diff.
  - step=0: count unchanged, tick=1, no pulses.
  - Saturated and still advancing outward: count stays at the bound and the matching pulse fires on every advance.
  - Count outside the bounds after a runtime bound change is handled by the same compares (e.g. count > hi_bound going up -> overflow path).
- tick=1 for exactly one cycle per advance, aligned with the count update.
- ovf_sticky:
  - next = (ovf_sticky & ~clr_flags) | ovf_event | unf_event.
  - An event in the same cycle as clr_flags leaves it set.
- Latency: every input takes effect on count one edge later; at_max, at_min and cfg_err follow their inputs combinationally.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, load=1 -> count=0x00, tick=0, pulses=0, ovf_sticky=0. Release rst -> counting starts on the next edge.
- Wrap up: lo=0, hi=9, step=1, up=1, sat_mode=0, presc_div=0, en=1 for 10 cycles -> count 1..9 then 0; ovf_pulse=1 only with the 9->0 update; ovf_sticky=1 afterwards.
- Saturate down: lo=5, hi=200, step=4, sat_mode=0->1, load 10, then en=1, up=0 -> 6, 5 (unf_pulse=1), then 5 again with unf_pulse=1; at_min=1.
- Prescaler: presc_div=3, step=1, en=1 -> count increments every 4th cycle; en=0 for 2 cycles mid-period delays the next increment by exactly 2 cycles; tick aligns with each increment.
- Load priority and clamp: hi=200, load=1, en=1, load_val=250 -> count=200, tick=0, no pulse. Then clr_flags=1 in the same cycle as an overflow -> ovf_sticky stays 1; clr_flags alone next cycle -> 0.
- Config error: lo=50, hi=40 -> cfg_err=1; count holds across 5 cycles of en=1 and load=1. Restore lo=40, hi=50 -> cfg_err=0 and counting resumes.

Source files
------------

// File: rtl/bounded_updown_counter_if.sv
// rtl/bounded_updown_counter_if.sv - control and status bundle for the bounded up/down counter
interface bounded_updown_counter_if #(
    parameter int WIDTH   = 8,
    parameter int STEP_W  = 4,
    parameter int PRESC_W = 8
);
    logic               en;
    logic               up;
    logic               sat_mode;
    logic [STEP_W-1:0]  step;
    logic [PRESC_W-1:0] presc_div;
    logic [WIDTH-1:0]   lo_bound;
    logic [WIDTH-1:0]   hi_bound;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic               clr_flags;
    logic [WIDTH-1:0]   count;
    logic               tick;
    logic               ovf_pulse;
    logic               unf_pulse;
    logic               ovf_sticky;
    logic               at_max;
    logic               at_min;
    logic               cfg_err;

    modport master (
        output en, up, sat_mode, step, presc_div, lo_bound, hi_bound,
               load, load_val, clr_flags,
        input  count, tick, ovf_pulse, unf_pulse, ovf_sticky,
               at_max, at_min, cfg_err
    );

    modport slave (
        input  en, up, sat_mode, step, presc_div, lo_bound, hi_bound,
               load, load_val, clr_flags,
        output count, tick, ovf_pulse, unf_pulse, ovf_sticky,
               at_max, at_min, cfg_err
    );
endinterface

// File: rtl/bounded_updown_counter.sv
// rtl/bounded_updown_counter.sv - bounded up/down counter with step, prescaler and wrap/saturate
module bounded_updown_counter #(
    parameter int               WIDTH   = 8,
    parameter int               STEP_W  = 4,
    parameter int               PRESC_W = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    bounded_updown_counter_if.slave bus
);
    // Two extra bits so that count - step is never truncated and keeps its sign.
    localparam int DW = WIDTH + 2;

    logic [WIDTH-1:0]   count_q;
    logic [PRESC_W-1:0] pcnt_q;
    logic               tick_q;
    logic               ovf_q;
    logic               unf_q;
    logic               sticky_q;

    logic                 cfg_err;
    logic [WIDTH-1:0]     load_clamped;
    logic                 fire;
    logic                 advance;
    logic [WIDTH:0]       sum;
    logic signed [DW-1:0] diff;
    logic                 ovf_hit;
    logic                 unf_hit;
    logic [WIDTH-1:0]     adv_val;
    logic                 ovf_ev;
    logic                 unf_ev;

    assign cfg_err = bus.lo_bound > bus.hi_bound;
    assign fire    = bus.en && (pcnt_q == bus.presc_div);
    assign advance = !cfg_err && !bus.load && fire;

    // Clamp the load value into the current window and compute the next advanced count.
    always_comb begin
        load_clamped = bus.load_val;
        if (bus.load_val < bus.lo_bound) begin
            load_clamped = bus.lo_bound;
        end else if (bus.load_val > bus.hi_bound) begin
            load_clamped = bus.hi_bound;
        end

        sum     = {1'b0, count_q} + (WIDTH+1)'(bus.step);
        diff    = signed'({2'b00, count_q}) - signed'(DW'(bus.step));
        ovf_hit = sum > {1'b0, bus.hi_bound};
        unf_hit = diff < signed'({2'b00, bus.lo_bound});

        adv_val = count_q;
        if (bus.up) begin
            if (ovf_hit) begin
                adv_val = bus.sat_mode ? bus.hi_bound : bus.lo_bound;
            end else begin
                adv_val = sum[WIDTH-1:0];
            end
        end else begin
            if (unf_hit) begin
                adv_val = bus.sat_mode ? bus.lo_bound : bus.hi_bound;
            end else begin
                adv_val = diff[WIDTH-1:0];
            end
        end

        ovf_ev = advance && bus.up && ovf_hit;
        unf_ev = advance && !bus.up && unf_hit;
    end

    // Count, prescaler and event registers; a bad bound window freezes everything but the flag clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= RST_VAL;
            pcnt_q   <= '0;
            tick_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            tick_q   <= advance;
            ovf_q    <= ovf_ev;
            unf_q    <= unf_ev;
            sticky_q <= (sticky_q & ~bus.clr_flags) | ovf_ev | unf_ev;
            if (!cfg_err) begin
                if (bus.load) begin
                    count_q <= load_clamped;
                    pcnt_q  <= '0;
                end else if (fire) begin
                    count_q <= adv_val;
                    pcnt_q  <= '0;
                end else if (bus.en) begin
                    pcnt_q  <= pcnt_q + PRESC_W'(1);
                end
            end
        end
    end

    assign bus.count      = count_q;
    assign bus.tick       = tick_q;
    assign bus.ovf_pulse  = ovf_q;
    assign bus.unf_pulse  = unf_q;
    assign bus.ovf_sticky = sticky_q;
    assign bus.at_max     = count_q == bus.hi_bound;
    assign bus.at_min     = count_q == bus.lo_bound;
    assign bus.cfg_err    = cfg_err;
endmodule
